// File: rtl/gcd_pkg.sv
// ============================================================================
// Module  : gcd_pkg
// Purpose : Shared state encoding and datapath select constants for the GCD
//           controller and its helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Datapath x/y operand selects
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Datapath register input bus select
    localparam logic BUS_SUB = 1'b0;
    localparam logic BUS_IN  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_B = 3'd1,
        ZCHK   = 3'd2,
        ITER   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage : gcd_pkg

`default_nettype wire

// File: rtl/gcd_iter_counter.sv
// ============================================================================
// Module  : gcd_iter_counter
// Purpose : Saturating subtraction-cycle counter with clear and limit compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_iter_counter #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] C_SAT   = '1;
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != C_SAT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == C_LIMIT);

endmodule : gcd_iter_counter

`default_nettype wire

// File: rtl/gcd_controller.sv
// ============================================================================
// Module  : gcd_controller
// Purpose : Control FSM for the subtract-based GCD datapath: operand intake,
//           iteration sequencing, timeout and result handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_controller
    import gcd_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_data,
    output logic [WIDTH-1:0] data_in,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    input  logic [WIDTH-1:0] Aout,
    input  logic [WIDTH-1:0] Bout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] iter_count,
    output logic             err_zero,
    output logic             err_timeout,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_result;
    logic             r_err_zero;
    logic             r_err_timeout;

    logic             w_ld_a;
    logic             w_ld_b;
    logic             w_sel1;
    logic             w_sel2;
    logic             w_cnt_clear;
    logic             w_cnt_inc;
    logic             w_at_limit;
    logic             w_a_zero;
    logic             w_b_zero;

    assign w_a_zero = (Aout == '0);
    assign w_b_zero = (Bout == '0);

    gcd_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_cnt_clear),
        .inc      (w_cnt_inc),
        .count    (iter_count),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flag priority in ITER is eq > timeout > gt > lt.
    always_comb begin
        w_next_state = r_state;
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_sel1       = SEL_A;
        w_sel2       = SEL_A;
        w_cnt_clear  = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (op_valid) begin
                    w_ld_a       = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_next_state = LOAD_B;
                end
            end
            LOAD_B: begin
                if (op_valid) begin
                    w_ld_b       = 1'b1;
                    w_next_state = ZCHK;
                end
            end
            ZCHK: begin
                w_next_state = (w_a_zero || w_b_zero) ? DONE : ITER;
            end
            ITER: begin
                if (eq || w_at_limit) begin
                    w_next_state = DONE;
                end else if (gt) begin
                    w_sel1    = SEL_A;
                    w_sel2    = SEL_B;
                    w_ld_a    = 1'b1;
                    w_cnt_inc = 1'b1;
                end else if (lt) begin
                    w_sel1    = SEL_B;
                    w_sel2    = SEL_A;
                    w_ld_b    = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result      <= '0;
            r_err_zero    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_valid) begin
                        r_err_zero    <= 1'b0;
                        r_err_timeout <= 1'b0;
                    end
                end
                ZCHK: begin
                    if (w_a_zero && w_b_zero) begin
                        r_result   <= '0;
                        r_err_zero <= 1'b1;
                    end else if (w_a_zero) begin
                        r_result <= Bout;
                    end else if (w_b_zero) begin
                        r_result <= Aout;
                    end
                end
                ITER: begin
                    if (eq) begin
                        r_result <= Aout;
                    end else if (w_at_limit) begin
                        r_result      <= '0;
                        r_err_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_in     = op_data;
    assign ldA         = w_ld_a;
    assign ldB         = w_ld_b;
    assign sel1        = w_sel1;
    assign sel2        = w_sel2;
    assign sel_in      = (r_state == ITER) ? BUS_SUB : BUS_IN;
    assign op_ready    = (r_state == IDLE) || (r_state == LOAD_B);
    assign res_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign result      = r_result;
    assign err_zero    = r_err_zero;
    assign err_timeout = r_err_timeout;

endmodule : gcd_controller

`default_nettype wire

// File: tb/tb_gcd_controller.sv
// ============================================================================
// Module  : tb_gcd_controller
// Purpose : Self-checking bench for gcd_controller with a behavioural datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_controller;

    localparam int W      = 16;
    localparam int CW     = 16;
    localparam int MAXI   = 100;
    localparam int LAT_TO = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [W-1:0]  op_data = '0;
    logic [W-1:0]  data_in;
    logic          ldA, ldB, sel1, sel2, sel_in;
    logic          lt, gt, eq;
    logic [W-1:0]  Aout = '0;
    logic [W-1:0]  Bout = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  result;
    logic [CW-1:0] iter_count;
    logic          err_zero, err_timeout, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gcd_controller #(.WIDTH(W), .MAX_ITER(MAXI), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_data(op_data), .data_in(data_in), .ldA(ldA), .ldB(ldB),
        .sel1(sel1), .sel2(sel2), .sel_in(sel_in), .lt(lt), .gt(gt), .eq(eq),
        .Aout(Aout), .Bout(Bout), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .iter_count(iter_count), .err_zero(err_zero),
        .err_timeout(err_timeout), .busy(busy)
    );

    // Behavioural datapath: registers keep their value through reset.
    logic [W-1:0] dp_x, dp_y, dp_bus;
    assign dp_x   = sel1 ? Bout : Aout;
    assign dp_y   = sel2 ? Bout : Aout;
    assign dp_bus = sel_in ? data_in : (dp_x - dp_y);
    assign lt     = (Aout < Bout);
    assign gt     = (Aout > Bout);
    assign eq     = (Aout == Bout);

    always @(posedge clk) begin
        if (ldA) Aout <= dp_bus;
        if (ldB) Bout <= dp_bus;
    end

    always @(negedge clk) begin
        n_checks++;
        if (ldA && ldB) begin
            n_fail++;
            $display("FAIL ld_exclusive: ldA=%0b ldB=%0b, required not both 1", ldA, ldB);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Reference: Euclid by division; subtraction count is sum of quotients minus one.
    function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                    output int unsigned res, output int unsigned n,
                                    output bit ez, output bit et, output int lat);
        int unsigned x, y, t, total;
        ez = 1'b0; et = 1'b0; n = 0; res = 0; lat = 2;
        if (a == 0 && b == 0) begin
            ez = 1'b1;
        end else if (a == 0) begin
            res = b;
        end else if (b == 0) begin
            res = a;
        end else begin
            x = a; y = b; total = 0;
            while (y != 0) begin
                total += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            n = total - 1;
            res = x;
            if (n > MAXI) begin
                et = 1'b1; res = 0; n = MAXI;
            end
            lat = int'(n) + 3;
        end
    endfunction

    // Presents A then B; returns with the bench #1 after the B handshake edge.
    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        check("op_ready_idle", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_data  = a;
        @(posedge clk); #1;
        check("op_ready_load_b", 32'(op_ready), 32'd1);
        op_data = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_data  = '0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!res_valid && lat < LAT_TO) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_valid_timeout: res_valid=0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("op_ready_after", 32'(op_ready), 32'd1);
    endtask

    task automatic run_and_check(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] e_res, input int e_n,
                                 input bit e_ez, input bit e_et, input int e_lat);
        int lat;
        load_ops(a, b);
        wait_result(lat);
        check("latency", 32'(lat), 32'(e_lat));
        check("result", 32'(result), 32'(e_res));
        check("iter_count", 32'(iter_count), 32'(e_n));
        check("err_zero", 32'(err_zero), 32'(e_ez));
        check("err_timeout", 32'(err_timeout), 32'(e_et));
        check("busy_done", 32'(busy), 32'd1);
        accept_result();
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           n;
        bit           ez;
        bit           et;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          lat;
        int unsigned r_res, r_n;
        bit          r_ez, r_et;
        int          r_lat;
        logic [W-1:0] ra, rb;

        vecs[0] = '{16'd48, 16'd18,    16'd6, 4,    1'b0, 1'b0, 7};
        vecs[1] = '{16'd7,  16'd7,     16'd7, 0,    1'b0, 1'b0, 3};
        vecs[2] = '{16'd0,  16'd5,     16'd5, 0,    1'b0, 1'b0, 2};
        vecs[3] = '{16'd0,  16'd0,     16'd0, 0,    1'b1, 1'b0, 2};
        vecs[4] = '{16'd9,  16'd0,     16'd9, 0,    1'b0, 1'b0, 2};
        vecs[5] = '{16'd1,  16'd65535, 16'd0, MAXI, 1'b0, 1'b1, MAXI + 3};
        vecs[6] = '{16'd21, 16'd14,    16'd7, 2,    1'b0, 1'b0, 5};
        vecs[7] = '{16'd1,  16'd101,   16'd1, MAXI, 1'b0, 1'b0, MAXI + 3};

        // Reset values
        #12;
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_iter", 32'(iter_count), 32'd0);
        check("rst_err_zero", 32'(err_zero), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ld", 32'({ldA, ldB}), 32'd0);
        check("rst_sel", 32'({sel1, sel2}), 32'd0);
        check("rst_sel_in", 32'(sel_in), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_and_check(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].n,
                          vecs[i].ez, vecs[i].et, vecs[i].lat);
        end

        // Result held while the host stalls; new operands are refused
        load_ops(16'd48, 16'd18);
        wait_result(lat);
        op_valid = 1'b1;
        op_data  = 16'd99;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_result", 32'(result), 32'd6);
            check("hold_iter", 32'(iter_count), 32'd4);
            check("hold_err", 32'({err_zero, err_timeout}), 32'd0);
            check("hold_op_ready", 32'(op_ready), 32'd0);
            check("hold_ld", 32'({ldA, ldB}), 32'd0);
        end
        op_valid = 1'b0;
        op_data  = '0;
        accept_result();

        // Asynchronous reset in the middle of a long iteration
        load_ops(16'd1, 16'd65535);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_sel_in", 32'(sel_in), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_op_ready", 32'(op_ready), 32'd1);
        check("arst_iter", 32'(iter_count), 32'd0);
        check("arst_sel_in", 32'(sel_in), 32'd1);
        check("arst_ld", 32'({ldA, ldB, sel1, sel2}), 32'd0);
        check("arst_res", 32'({res_valid, err_zero, err_timeout}), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_and_check(16'd21, 16'd14, 16'd7, 2, 1'b0, 1'b0, 5);

        // Randomised operands against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       begin ra = '0; rb = W'($urandom_range(0, 50)); end
                1:       begin ra = W'($urandom_range(0, 50)); rb = '0; end
                2:       begin ra = W'($urandom_range(1, 3)); rb = W'($urandom_range(150, 2000)); end
                default: begin ra = W'($urandom_range(1, 300)); rb = W'($urandom_range(1, 300)); end
            endcase
            ref_gcd(ra, rb, r_res, r_n, r_ez, r_et, r_lat);
            run_and_check(ra, rb, W'(r_res), int'(r_n), r_ez, r_et, r_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gcd_controller

`default_nettype wire
